// File: rtl/sram_responder.sv
// sram_responder: shared word RAM answering the core's inst/data SRAM ports,
// plus a timer/LED/switch/scratch peripheral window on the data port.
module sram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch_in
);
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] timer, scratch, timer_nxt, scratch_nxt, mmio_rdata;
    logic [15:0] led_nxt, off;
    logic [7:0]  sw_s1, sw_s2;
    logic [ADDR_W-1:0] i_idx, d_idx;
    logic i_mmio, d_mmio, d_wr, d_rd, unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? n[8*i+:8] : o[8*i+:8];
        return r;
    endfunction

    assign unused_ok = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr, data_sram_addr};

    always_comb begin
        i_mmio      = inst_sram_addr[31:16] == MMIO_BASE;
        d_mmio      = data_sram_addr[31:16] == MMIO_BASE;
        i_idx       = inst_sram_addr[ADDR_W+1:2];
        d_idx       = data_sram_addr[ADDR_W+1:2];
        off         = data_sram_addr[15:0];
        d_wr        = data_sram_en && |data_sram_wen;
        d_rd        = data_sram_en && !(|data_sram_wen);
        // a timer write wins over the increment in the same cycle
        timer_nxt   = (d_wr && d_mmio && off == 16'h0000) ? merge(timer, data_sram_wdata, data_sram_wen) : timer + 32'd1;
        scratch_nxt = merge(scratch, data_sram_wdata, data_sram_wen);
        led_nxt     = {data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8],
                       data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0]};
        mmio_rdata  = off == 16'h0000 ? timer_nxt :
                      off == 16'h0004 ? {16'h0000, led} :
                      off == 16'h0008 ? {24'h000000, sw_s2} :
                      off == 16'h000C ? scratch : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
            led             <= '0;
            timer           <= '0;
            scratch         <= '0;
            sw_s1           <= '0;
            sw_s2           <= '0;
        end else begin
            sw_s1 <= switch_in;
            sw_s2 <= sw_s1;
            timer <= timer_nxt;
            if (inst_sram_en) inst_sram_rdata <= i_mmio ? 32'h0 : mem[i_idx];
            if (d_rd) data_sram_rdata <= d_mmio ? mmio_rdata : mem[d_idx];
            if (d_wr && d_mmio && off == 16'h0004) led <= led_nxt;
            if (d_wr && d_mmio && off == 16'h000C) scratch <= scratch_nxt;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (d_wr && !d_mmio)
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i]) mem[d_idx][8*i+:8] <= data_sram_wdata[8*i+:8];
    end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the CPU core's inst and data SRAM interfaces. It is the target that answers inst_sram_* and data_sram_* requests.
- Contains one shared word-addressed RAM with a 1-cycle synchronous read, plus a small memory-mapped peripheral region on the data port: a free-running timer, LEDs, switches and a scratch register.
- Sits beside the core in the SoC top; it stands in for board block RAM and the confreg-style peripherals.

Parameters:
ADDR_W, 12, RAM word-address width (2^ADDR_W words; byte address bits [ADDR_W+1:2] select the word).
MMIO_BASE, 16'hBFAF, value of addr[31:16] that selects the peripheral region on the data port.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
inst_sram_en  input  1  inst request strobe
inst_sram_wen  input  4  inst byte write enables (ignored; inst port is read-only)
inst_sram_addr  input  32  inst byte address
inst_sram_wdata  input  32  ignored
inst_sram_rdata  output  32  inst read data, valid 1 cycle after request
data_sram_en  input  1  data request strobe
data_sram_wen  input  4  data byte write enables; 4'b0000 means read
data_sram_addr  input  32  data byte address
data_sram_wdata  input  32  data write data
data_sram_rdata  output  32  data read data, valid 1 cycle after read request
led  output  16  LED register value
switch_in  input  8  asynchronous board switches

Behaviour:
- Reset is asynchronous on resetn low. On reset:
  - inst_sram_rdata=0, data_sram_rdata=0, led=16'h0000, timer=0, scratch=0.
  - Switch synchronizer flops are cleared.
  - RAM contents are not reset.
- Request acceptance: there is no stall or handshake. Every cycle with en=1 is an accepted request on that port.
- Inst port:
  - en=1: inst_sram_rdata <= RAM[addr[ADDR_W+1:2]] at the next clock edge.
  - en=0: rdata holds its previous value.
  - Inst addresses whose addr[31:16]==MMIO_BASE return 0.
- Data-port decode: MMIO when addr[31:16]==MMIO_BASE, otherwise RAM. RAM addresses wrap, so bits above ADDR_W+1 are ignored.
- Data read (en=1, wen=0): data_sram_rdata <= selected word at the next edge, 1-cycle latency.
- Data write (en=1, wen!=0):
  - Each byte lane i with wen[i]=1 is written at the edge.
  - Lanes with wen[i]=0 keep their old contents.
  - data_sram_rdata holds its previous value; it is updated only by reads.
- Ordering:
  - A write in cycle N followed by a read of the same word in cycle N+1 returns the new data.
  - An inst read and a data write to the same RAM word in the same cycle: inst returns the old data (read-before-write).
- MMIO map (offset = addr[15:0]):
  - 0x0000 TIMER, 32-bit read/write. Increments by 1 every cycle and wraps 32'hFFFFFFFF->0. A byte-masked write at edge N loads the merged value, and the timer reads value+1 at edge N+1. The write has priority over the increment in the same cycle. A read returns the value registered at the request edge.
  - 0x0004 LED, 32-bit read/write, bits [15:0] used, byte-enable merged. Upper bits read 0; writes to bytes 2-3 are ignored. led output updates at the write edge.
  - 0x0008 SWITCH, read-only. Returns {24'b0, two-flop-synchronized switch_in}. Writes are ignored.
  - 0x000C SCRATCH, 32-bit read/write, byte-enable merged.
  - Any other offset reads 0; writes are ignored. There is no error signal.
- Simultaneous events:
  - Inst and data ports operate independently in the same cycle.
  - The timer increments whether or not it is accessed.
- Reset mid-operation: an in-flight read is dropped and rdata reads 0 after reset. RAM contents persist across reset.

Test Plan:
1. Reset then RAM write/read: data write addr 0x0000_0010, wdata 32'hDEADBEEF, wen 4'hF; next cycle read the same address -> data_sram_rdata==32'hDEADBEEF one cycle after the read. Inst read of 0x10 -> inst_sram_rdata==32'hDEADBEEF.
2. Byte-lane merge: word holds 32'h11223344; write wen=4'b0101, wdata 32'hAABBCCDD; read -> 32'h11BB33DD.
3. Same-cycle conflict: word 0x20 holds 32'h0; inst read and data write 32'h5 to 0x20 in the same cycle -> inst_sram_rdata==0; the inst read on the following cycle ==5. Wrap check: data read of byte address 2^(ADDR_W+2)+0x20 returns 5.
4. Timer: write 32'hFFFFFFFE to 0xBFAF0000 at edge N; read issued at cycle N+2 -> 32'h0 (wrapped). A read issued with no write returns a value that increases by exactly 1 per cycle of issue.
5. LED/switch/scratch/unmapped:
   - Write 32'h1234ABCD to 0xBFAF0004 -> led==16'hABCD; readback==32'h0000ABCD.
   - Set switch_in=8'h5A; a read of 0xBFAF0008 issued ≥3 cycles later returns 32'h5A.
   - Write 0x0BADF00D to 0xBFAF000C -> readback 0x0BADF00D.
   - Read 0xBFAF0100 -> 0; inst read of 0xBFAF0004 -> 0.
6. Async reset mid-run: assert resetn low between edges while a read is pending -> both rdata outputs, led and timer go to 0 immediately. After release, RAM word 0x10 still reads 32'hDEADBEEF.
